// File: rtl/shop_pkg.sv
// Shared command keys, response strings, opcodes and FSM states
// for the shop_db_v command database.
package shop_pkg;

  localparam int KEY_W = 56;
  localparam int RSP_W = 72;

  typedef enum logic [2:0] {
    OP_BAD,
    OP_LOGOUT,
    OP_LOGIN,
    OP_ADDUSR,
    OP_DELUSR,
    OP_ADDITEM,
    OP_DELITEM,
    OP_BUY
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_RESP
  } state_e;

  localparam logic [KEY_W-1:0] KEY_LOGOUT  = KEY_W'("Logout");
  localparam logic [KEY_W-1:0] KEY_LOGIN   = KEY_W'("Login");
  localparam logic [KEY_W-1:0] KEY_ADDUSR  = KEY_W'("AddUsr");
  localparam logic [KEY_W-1:0] KEY_DELUSR  = KEY_W'("DelUsr");
  localparam logic [KEY_W-1:0] KEY_ADDITEM = KEY_W'("AddItem");
  localparam logic [KEY_W-1:0] KEY_DELITEM = KEY_W'("DelItem");
  localparam logic [KEY_W-1:0] KEY_BUY     = KEY_W'("Buy");

  localparam logic [RSP_W-1:0] RSP_PROMPT  = RSP_W'("Cmd?");
  localparam logic [RSP_W-1:0] RSP_BADCMD  = RSP_W'("InvalCmd");
  localparam logic [RSP_W-1:0] RSP_PERM    = RSP_W'("InvalPerm");
  localparam logic [RSP_W-1:0] RSP_BADUSR  = RSP_W'("InvalUsr");
  localparam logic [RSP_W-1:0] RSP_BADITEM = RSP_W'("InvalItem");
  localparam logic [RSP_W-1:0] RSP_WELCOME = RSP_W'("Welcome");
  localparam logic [RSP_W-1:0] RSP_BYE     = RSP_W'("Bye");
  localparam logic [RSP_W-1:0] RSP_UEXIST  = RSP_W'("UsrExist");
  localparam logic [RSP_W-1:0] RSP_UADDED  = RSP_W'("UsrAdded");
  localparam logic [RSP_W-1:0] RSP_UDEL    = RSP_W'("UsrDel");
  localparam logic [RSP_W-1:0] RSP_OVF     = RSP_W'("Overflow");
  localparam logic [RSP_W-1:0] RSP_IADD    = RSP_W'("ItemAdd");
  localparam logic [RSP_W-1:0] RSP_IDEL    = RSP_W'("ItemDel");
  localparam logic [RSP_W-1:0] RSP_NOSTOCK = RSP_W'("NoStock");
  localparam logic [RSP_W-1:0] RSP_BOUGHT  = RSP_W'("Bought");

endpackage

// File: rtl/shop_cmd_decode_v.sv
// Combinational match of a right-justified ASCII command key
// against the known keys; anything else decodes to OP_BAD.
module shop_cmd_decode_v
  import shop_pkg::*;
#(
  parameter int W = 56
) (
  input  logic [W-1:0] key,
  output op_e          op
);

  always_comb begin
    op = OP_BAD;
    unique case (1'b1)
      key == W'(KEY_LOGOUT):  op = OP_LOGOUT;
      key == W'(KEY_LOGIN):   op = OP_LOGIN;
      key == W'(KEY_ADDUSR):  op = OP_ADDUSR;
      key == W'(KEY_DELUSR):  op = OP_DELUSR;
      key == W'(KEY_ADDITEM): op = OP_ADDITEM;
      key == W'(KEY_DELITEM): op = OP_DELITEM;
      key == W'(KEY_BUY):     op = OP_BUY;
      default:                op = OP_BAD;
    endcase
  end

endmodule

// File: rtl/shop_db_v.sv
// Shop database: users, login session and item stock driven by
// strobed ASCII commands, answered with held ASCII responses.
module shop_db_v
  import shop_pkg::*;
#(
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4,
  parameter int MAX_USERS           = 5,
  parameter int MAX_ITEMS           = 8,
  parameter int QTY_NUM_BITS        = 8,
  parameter int RESP_HOLD           = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_rdy,
  input  logic [I_U_NUM_BITS-1:0]          i_u,
  input  logic [I_A_NUM_ASCII_CHARS*8-1:0] i_a,
  input  logic [QTY_NUM_BITS-1:0]          i_n,
  output logic [O_A_NUM_ASCII_CHARS*8-1:0] o_a,
  output logic                             o_vld,
  output logic                             o_busy
);

  localparam int AW  = I_A_NUM_ASCII_CHARS * 8;
  localparam int OW  = O_A_NUM_ASCII_CHARS * 8;
  localparam int UB  = I_U_NUM_BITS;
  localparam int QB  = QTY_NUM_BITS;
  localparam int UIW = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
  localparam int IIW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam int HW  = $clog2(RESP_HOLD + 1);

  localparam logic [UB:0]   USR_LIM   = (UB+1)'(MAX_USERS);
  localparam logic [UB:0]   ITM_LIM   = (UB+1)'(MAX_ITEMS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESP_HOLD - 1);

  state_e                 state;
  state_e                 state_nx;
  logic                   rdy_q;
  logic                   accept;
  logic [AW-1:0]          cap_a;
  logic [UB-1:0]          cap_u;
  logic [QB-1:0]          cap_n;
  op_e                    dec_op;
  op_e                    op_q;
  logic                   sess_on;
  logic [UB-1:0]          sess_id;
  logic [MAX_USERS-1:0]   usr_vld;
  logic [QB-1:0]          qty [MAX_ITEMS];
  logic [OW-1:0]          rsp_q;
  logic [HW-1:0]          hold_q;
  logic                   vld_q;

  logic                   usr_ok;
  logic                   itm_ok;
  logic                   slot;
  logic                   admin;
  logic [UIW-1:0]         uidx;
  logic [IIW-1:0]         iidx;
  logic [QB-1:0]          cur;
  logic [QB:0]            sum;

  logic [OW-1:0]          rsp_nx;
  logic                   sess_set;
  logic                   sess_clr;
  logic                   usr_wr;
  logic                   usr_val;
  logic                   qty_wr;
  logic [QB-1:0]          qty_val;

  shop_cmd_decode_v #(.W(AW)) u_dec (
    .key (cap_a),
    .op  (dec_op)
  );

  assign accept = i_rdy && !rdy_q && (state == S_IDLE);
  assign o_busy = (state != S_IDLE);
  assign o_vld  = vld_q;
  assign o_a    = (state == S_RESP) ? rsp_q : OW'(RSP_PROMPT);

  assign uidx   = UIW'(cap_u);
  assign iidx   = IIW'(cap_u);
  assign usr_ok = {1'b0, cap_u} < USR_LIM;
  assign itm_ok = {1'b0, cap_u} < ITM_LIM;
  assign slot   = usr_ok && usr_vld[uidx];
  assign admin  = sess_on && (sess_id == '0);
  assign cur    = itm_ok ? qty[iidx] : '0;
  assign sum    = {1'b0, cur} + {1'b0, cap_n};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (accept) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_RESP;
      S_RESP:   if (hold_q == HOLD_LAST) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Permission is always judged before the operand.
  always_comb begin
    rsp_nx   = OW'(RSP_BADCMD);
    sess_set = 1'b0;
    sess_clr = 1'b0;
    usr_wr   = 1'b0;
    usr_val  = 1'b0;
    qty_wr   = 1'b0;
    qty_val  = cur;
    unique case (op_q)
      OP_LOGIN: begin
        if (sess_on)    rsp_nx = OW'(RSP_PERM);
        else if (!slot) rsp_nx = OW'(RSP_BADUSR);
        else begin
          sess_set = 1'b1;
          rsp_nx   = OW'(RSP_WELCOME);
        end
      end
      OP_LOGOUT: begin
        if (!sess_on) rsp_nx = OW'(RSP_PERM);
        else begin
          sess_clr = 1'b1;
          rsp_nx   = OW'(RSP_BYE);
        end
      end
      OP_ADDUSR: begin
        if (!admin)       rsp_nx = OW'(RSP_PERM);
        else if (!usr_ok) rsp_nx = OW'(RSP_BADUSR);
        else if (slot)    rsp_nx = OW'(RSP_UEXIST);
        else begin
          usr_wr  = 1'b1;
          usr_val = 1'b1;
          rsp_nx  = OW'(RSP_UADDED);
        end
      end
      OP_DELUSR: begin
        if (!admin) rsp_nx = OW'(RSP_PERM);
        else if (cap_u == '0 || !slot)
          rsp_nx = OW'(RSP_BADUSR);
        else begin
          usr_wr = 1'b1;
          rsp_nx = OW'(RSP_UDEL);
        end
      end
      OP_ADDITEM: begin
        if (!admin)       rsp_nx = OW'(RSP_PERM);
        else if (!itm_ok) rsp_nx = OW'(RSP_BADITEM);
        else if (sum[QB]) rsp_nx = OW'(RSP_OVF);
        else begin
          qty_wr  = 1'b1;
          qty_val = sum[QB-1:0];
          rsp_nx  = OW'(RSP_IADD);
        end
      end
      OP_DELITEM: begin
        if (!admin)       rsp_nx = OW'(RSP_PERM);
        else if (!itm_ok) rsp_nx = OW'(RSP_BADITEM);
        else begin
          qty_wr  = 1'b1;
          qty_val = '0;
          rsp_nx  = OW'(RSP_IDEL);
        end
      end
      OP_BUY: begin
        if (!sess_on || admin) rsp_nx = OW'(RSP_PERM);
        else if (!itm_ok)      rsp_nx = OW'(RSP_BADITEM);
        else if (cap_n == '0 || cap_n > cur)
          rsp_nx = OW'(RSP_NOSTOCK);
        else begin
          qty_wr  = 1'b1;
          qty_val = cur - cap_n;
          rsp_nx  = OW'(RSP_BOUGHT);
        end
      end
      default: rsp_nx = OW'(RSP_BADCMD);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      cap_a      <= '0;
      cap_u      <= '0;
      cap_n      <= '0;
      op_q       <= OP_BAD;
      hold_q     <= '0;
      rsp_q      <= OW'(RSP_PROMPT);
      sess_on    <= 1'b0;
      sess_id    <= '0;
      usr_vld    <= '0;
      usr_vld[0] <= 1'b1;
      for (int i = 0; i < MAX_ITEMS; i++) qty[i] <= '0;
    end else begin
      rdy_q <= i_rdy;
      vld_q <= (state == S_EXEC);
      if (accept) begin
        cap_a <= i_a;
        cap_u <= i_u;
        cap_n <= i_n;
      end
      if (state == S_DECODE) op_q <= dec_op;
      if (state == S_RESP) hold_q <= hold_q + 1'b1;
      else                 hold_q <= '0;
      if (state == S_EXEC) begin
        rsp_q <= rsp_nx;
        if (sess_set) begin
          sess_on <= 1'b1;
          sess_id <= cap_u;
        end
        if (sess_clr) begin
          sess_on <= 1'b0;
          sess_id <= '0;
        end
        if (usr_wr) usr_vld[uidx] <= usr_val;
        if (qty_wr) qty[iidx] <= qty_val;
      end
    end
  end

endmodule

// File: tb/tb_shop_db_v.sv
// Directed bench for shop_db_v with a shop-level reference model
// checked against the DUT outputs every cycle.
module tb_shop_db_v;

  localparam int H    = 4;
  localparam int MU   = 5;
  localparam int MI   = 8;
  localparam int QMAX = 255;
  localparam logic [71:0] PROMPT = 72'("Cmd?");

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rdy = 1'b0;
  logic [3:0]  i_u = '0;
  logic [55:0] i_a = '0;
  logic [7:0]  i_n = '0;
  logic [71:0] o_a;
  logic        o_vld;
  logic        o_busy;

  int n_chk = 0;
  int n_pass = 0;
  int edges = 0;
  int acc = -1;
  logic [71:0] m_rsp = '0;

  bit m_in;
  int m_sid;
  bit m_uv [16];
  int m_qty [16];

  shop_db_v dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_rdy   (i_rdy),
    .i_u     (i_u),
    .i_a     (i_a),
    .i_n     (i_n),
    .o_a     (o_a),
    .o_vld   (o_vld),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic void m_reset();
    m_in = 0;
    m_sid = 0;
    for (int i = 0; i < 16; i++) begin
      m_uv[i] = 0;
      m_qty[i] = 0;
    end
    m_uv[0] = 1;
  endfunction

  function automatic logic [71:0] model(
    input logic [55:0] a, input int u, input int n);
    bit adm;
    bit usr;
    adm = m_in && m_sid == 0;
    usr = m_in && m_sid != 0;
    if (a == 56'("Login")) begin
      if (m_in) return 72'("InvalPerm");
      if (u >= MU || !m_uv[u]) return 72'("InvalUsr");
      m_in = 1;
      m_sid = u;
      return 72'("Welcome");
    end
    if (a == 56'("Logout")) begin
      if (!m_in) return 72'("InvalPerm");
      m_in = 0;
      m_sid = 0;
      return 72'("Bye");
    end
    if (a == 56'("AddUsr")) begin
      if (!adm) return 72'("InvalPerm");
      if (u >= MU) return 72'("InvalUsr");
      if (m_uv[u]) return 72'("UsrExist");
      m_uv[u] = 1;
      return 72'("UsrAdded");
    end
    if (a == 56'("DelUsr")) begin
      if (!adm) return 72'("InvalPerm");
      if (u == 0 || u >= MU || !m_uv[u]) return 72'("InvalUsr");
      m_uv[u] = 0;
      return 72'("UsrDel");
    end
    if (a == 56'("AddItem")) begin
      if (!adm) return 72'("InvalPerm");
      if (u >= MI) return 72'("InvalItem");
      if (m_qty[u] + n > QMAX) return 72'("Overflow");
      m_qty[u] = m_qty[u] + n;
      return 72'("ItemAdd");
    end
    if (a == 56'("DelItem")) begin
      if (!adm) return 72'("InvalPerm");
      if (u >= MI) return 72'("InvalItem");
      m_qty[u] = 0;
      return 72'("ItemDel");
    end
    if (a == 56'("Buy")) begin
      if (!usr) return 72'("InvalPerm");
      if (u >= MI) return 72'("InvalItem");
      if (n == 0 || n > m_qty[u]) return 72'("NoStock");
      m_qty[u] = m_qty[u] - n;
      return 72'("Bought");
    end
    return 72'("InvalCmd");
  endfunction

  // Expected outputs follow from cycles elapsed since acceptance.
  always @(negedge clk) begin
    if (edges > 0) begin
      int d;
      logic [71:0] ea;
      bit ev;
      bit eb;
      d  = (acc < 0) ? 1000 : edges - acc;
      eb = (d >= 0) && (d < H + 2);
      ev = (d == 2);
      ea = (d >= 2 && d < H + 2) ? m_rsp : PROMPT;
      n_chk++;
      if (o_a === ea && o_vld === ev && o_busy === eb)
        n_pass++;
      else
        $display("FAIL cycle@%0d: o_a='%s' vld=%b busy=%b need '%s' %b %b",
                 edges, o_a, o_vld, o_busy, ea, ev, eb);
    end
  end

  task automatic chk(input string nm, input bit ok,
                     input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got '%s' need '%s'", nm, act, exp);
  endtask

  task automatic cmd(input logic [55:0] a, input logic [3:0] u,
                     input logic [7:0] n, input logic [71:0] exp,
                     input bit dup);
    @(negedge clk); #1;
    i_a = a;
    i_u = u;
    i_n = n;
    i_rdy = 1'b1;
    m_rsp = model(a, int'(u), int'(n));
    acc = edges + 1;
    @(negedge clk); #1;
    i_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rsp", o_a === exp && o_vld === 1'b1, o_a, exp);
    if (dup) begin
      #1;
      i_a = 56'("DelUsr");
      i_rdy = 1'b1;
    end
    for (int i = 0; i < H; i++) begin
      @(negedge clk); #1;
      i_rdy = 1'b0;
    end
  endtask

  task automatic cmd_rst(input logic [55:0] a, input logic [3:0] u);
    @(negedge clk); #1;
    i_a = a;
    i_u = u;
    i_n = '0;
    i_rdy = 1'b1;
    m_rsp = model(a, int'(u), 0);
    acc = edges + 1;
    @(negedge clk); #1;
    i_rdy = 1'b0;
    @(negedge clk); #1;
    i_reset = 1'b1;
    acc = -1;
    m_reset();
    @(negedge clk);
    chk("rst_exec", o_a === PROMPT && !o_busy && !o_vld, o_a, PROMPT);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset", o_a === PROMPT && o_busy === 1'b0 && o_vld === 1'b0,
        o_a, PROMPT);
    #1;
    i_reset = 1'b0;

    cmd(56'("sdfsdf"), 4'd0, 8'd0, 72'("InvalCmd"), 0);
    cmd(56'("AddItem"), 4'd3, 8'd5, 72'("InvalPerm"), 0);

    cmd(56'("Login"), 4'd0, 8'd0, 72'("Welcome"), 0);
    cmd(56'("AddUsr"), 4'd2, 8'd0, 72'("UsrAdded"), 0);
    cmd(56'("AddItem"), 4'd3, 8'd10, 72'("ItemAdd"), 0);
    cmd(56'("Logout"), 4'd0, 8'd0, 72'("Bye"), 0);
    cmd(56'("Login"), 4'd2, 8'd0, 72'("Welcome"), 0);
    cmd(56'("Buy"), 4'd3, 8'd4, 72'("Bought"), 0);
    cmd(56'("Buy"), 4'd3, 8'd7, 72'("NoStock"), 0);
    cmd(56'("Buy"), 4'd3, 8'd6, 72'("Bought"), 0);
    cmd(56'("Buy"), 4'd3, 8'd1, 72'("NoStock"), 0);

    cmd(56'("Login"), 4'd0, 8'd0, 72'("InvalPerm"), 0);
    cmd(56'("Logout"), 4'd0, 8'd0, 72'("Bye"), 0);
    cmd(56'("Login"), 4'd7, 8'd0, 72'("InvalUsr"), 0);
    cmd(56'("Login"), 4'd0, 8'd0, 72'("Welcome"), 0);
    cmd(56'("Buy"), 4'd1, 8'd1, 72'("InvalPerm"), 0);
    cmd(56'("AddItem"), 4'd1, 8'd250, 72'("ItemAdd"), 0);
    cmd(56'("AddItem"), 4'd1, 8'd10, 72'("Overflow"), 0);
    cmd(56'("AddItem"), 4'd9, 8'd1, 72'("InvalItem"), 0);
    cmd(56'("AddUsr"), 4'd5, 8'd0, 72'("InvalUsr"), 0);
    cmd(56'("AddUsr"), 4'd2, 8'd0, 72'("UsrExist"), 0);
    cmd(56'("DelUsr"), 4'd0, 8'd0, 72'("InvalUsr"), 0);
    cmd(56'("Logout"), 4'd0, 8'd0, 72'("Bye"), 0);
    cmd(56'("Login"), 4'd2, 8'd0, 72'("Welcome"), 0);
    cmd(56'("Buy"), 4'd1, 8'd251, 72'("NoStock"), 0);
    cmd(56'("Buy"), 4'd1, 8'd0, 72'("NoStock"), 0);
    cmd(56'("Buy"), 4'd8, 8'd1, 72'("InvalItem"), 0);
    cmd(56'("Buy"), 4'd1, 8'd250, 72'("Bought"), 0);
    cmd(56'("AddUsr"), 4'd3, 8'd0, 72'("InvalPerm"), 0);
    cmd(56'("Logout"), 4'd0, 8'd0, 72'("Bye"), 0);
    cmd(56'("Logout"), 4'd0, 8'd0, 72'("InvalPerm"), 0);

    cmd(56'("Login"), 4'd0, 8'd0, 72'("Welcome"), 0);
    cmd(56'("AddUsr"), 4'd4, 8'd0, 72'("UsrAdded"), 1);
    cmd(56'("AddUsr"), 4'd4, 8'd0, 72'("UsrExist"), 0);
    cmd(56'("DelUsr"), 4'd4, 8'd0, 72'("UsrDel"), 0);
    cmd(56'("DelItem"), 4'd3, 8'd0, 72'("ItemDel"), 0);
    cmd(56'("DelItem"), 4'd8, 8'd0, 72'("InvalItem"), 0);

    cmd_rst(56'("AddUsr"), 4'd3);
    cmd(56'("Login"), 4'd0, 8'd0, 72'("Welcome"), 0);
    cmd(56'("DelUsr"), 4'd3, 8'd0, 72'("InvalUsr"), 0);
    cmd(56'("AddUsr"), 4'd2, 8'd0, 72'("UsrAdded"), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
